// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM request arbiter: FSM states,
// requester ids and the byte-address window split.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD0,
    RD1,
    DONE
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Byte-offset bits dropped when converting a byte address to a word address.
  localparam int BYTE_LSBS = 2;

  // Lowest byte-address bit that selects the SRAM window rather than a word.
  function automatic int win_lsb(input int addr_width);
    return addr_width + BYTE_LSBS;
  endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant between the instruction (I) and data (D) requesters.
// The grant is combinational; last_grant advances only when the FSM accepts it.
module sram_rr_arbiter
  import sram_arb_pkg::*;
(
  input  logic clk,
  input  logic nRst,
  input  logic i_req,
  input  logic d_req,
  input  logic update,
  output logic grant_valid,
  output logic grant_d
);

  port_e last_grant;
  port_e winner;

  always_comb begin
    // NOTE: winner gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    winner = PORT_I;
    if (i_req && d_req) begin
      winner = (last_grant == PORT_I) ? PORT_D : PORT_I;
    end else if (d_req) begin
      winner = PORT_D;
    end
  end

  assign grant_valid = i_req | d_req;
  assign grant_d     = (winner == PORT_D);

  // Reset to I so the first tie after reset goes to D.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      last_grant <= PORT_I;
    end else if (update && grant_valid) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Front-end for a 1W/1R SRAM macro: round-robin between an instruction reader
// and a data read/write port, byte-to-word address translation, registered acks.
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int          ADDR_WIDTH = 11,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_WMASKS = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  output logic                  i_ack,
  output logic                  i_err,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [NUM_WMASKS-1:0] d_sel,
  input  logic [31:0]           d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic                  d_err,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int WIN_LSB = win_lsb(ADDR_WIDTH);

  state_e                state;
  port_e                 cur_port;
  logic                  gnt_valid;
  logic                  gnt_d;
  logic [31:0]           sel_addr;
  logic [ADDR_WIDTH-1:0] word;
  logic                  in_range;
  logic                  is_write;

  sram_rr_arbiter u_rr (
    .clk         (clk),
    .nRst        (nRst),
    .i_req       (i_req),
    .d_req       (d_req),
    .update      (state == IDLE),
    .grant_valid (gnt_valid),
    .grant_d     (gnt_d)
  );

  assign sel_addr = gnt_d ? d_addr : i_addr;
  assign word     = sel_addr[WIN_LSB-1:BYTE_LSBS];
  assign in_range = (sel_addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
  assign is_write = gnt_d & d_we;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= IDLE;
      cur_port    <= PORT_I;
      sram_csb0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      sram_csb1   <= 1'b1;
      sram_addr1  <= '0;
      i_ack       <= 1'b0;
      i_err       <= 1'b0;
      i_rdata     <= '0;
      d_ack       <= 1'b0;
      d_err       <= 1'b0;
      d_rdata     <= '0;
    end else begin
      // NOTE: all state and outputs use <= so every branch reads the
      // pre-edge values, matching the registered SRAM interface timing.
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            cur_port <= port_e'(gnt_d);
            if (!in_range) begin
              // Reject without touching the SRAM; ack on the very next cycle.
              if (gnt_d) begin
                d_ack   <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end else begin
                i_ack   <= 1'b1;
                i_err   <= 1'b1;
                i_rdata <= '0;
              end
              state <= DONE;
            end else if (is_write) begin
              sram_csb0   <= 1'b0;
              sram_wmask0 <= d_sel;
              sram_addr0  <= word;
              sram_din0   <= d_wdata;
              state       <= WR;
            end else begin
              sram_csb1  <= 1'b0;
              sram_addr1 <= word;
              state      <= RD0;
            end
          end
        end
        WR: begin
          sram_csb0   <= 1'b1;
          sram_wmask0 <= '0;
          d_ack       <= 1'b1;
          state       <= DONE;
        end
        RD0: begin
          sram_csb1 <= 1'b1;
          state     <= RD1;
        end
        RD1: begin
          // The macro drove dout1 on the negedge after its capture edge.
          if (cur_port == PORT_D) begin
            d_rdata <= sram_dout1;
            d_ack   <= 1'b1;
          end else begin
            i_rdata <= sram_dout1;
            i_ack   <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          i_ack <= 1'b0;
          i_err <= 1'b0;
          d_ack <= 1'b0;
          d_err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter with a behavioural 2048x32 1W/1R SRAM
// (posedge capture, negedge array access) attached to the SRAM ports.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        nRst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack, i_err;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_addr, d_wdata;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic        sram_csb0, sram_csb1;
  logic [3:0]  sram_wmask0;
  logic [10:0] sram_addr0, sram_addr1;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(
    .ADDR_WIDTH (11),
    .DATA_WIDTH (32),
    .NUM_WMASKS (4),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .nRst        (nRst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_ack       (i_ack),
    .i_err       (i_err),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_sel       (d_sel),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .d_err       (d_err),
    .d_rdata     (d_rdata),
    .sram_csb0   (sram_csb0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_csb1   (sram_csb1),
    .sram_addr1  (sram_addr1),
    .sram_dout1  (sram_dout1)
  );

  // Behavioural SRAM macro.
  logic [31:0] mem [0:2047];
  logic        csb0_q = 1'b1;
  logic        csb1_q = 1'b1;
  logic [3:0]  wm_q;
  logic [10:0] a0_q, a1_q;
  logic [31:0] din_q;

  always @(posedge clk) begin
    csb0_q <= sram_csb0;
    csb1_q <= sram_csb1;
    wm_q   <= sram_wmask0;
    a0_q   <= sram_addr0;
    a1_q   <= sram_addr1;
    din_q  <= sram_din0;
  end

  always @(negedge clk) begin
    if (!csb0_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wm_q[b]) mem[a0_q][8*b +: 8] <= din_q[8*b +: 8];
      end
    end
    if (!csb1_q) sram_dout1 <= mem[a1_q];
  end

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one D transaction; lat = edges from request sample to visible ack, 0 on timeout.
  task automatic d_txn(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat);
    d_req = 1'b1; d_we = we; d_sel = sel; d_addr = addr; d_wdata = wdata;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (d_ack === 1'b1) begin
        lat = n;
        break;
      end
    end
    d_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_sel = '0; d_addr = '0; d_wdata = '0;
    #12;
    checks++;
    if ({sram_csb0, sram_csb1, sram_wmask0} !== 6'b11_0000) begin
      errors++;
      $display("FAIL reset_sram_ctrl: got csb0=%b csb1=%b wmask0=%h, want 1 1 0", sram_csb0, sram_csb1, sram_wmask0);
    end
    checks++;
    if (sram_addr0 !== 11'd0 || sram_addr1 !== 11'd0 || sram_din0 !== 32'd0) begin
      errors++;
      $display("FAIL reset_sram_addr: got addr0=%h addr1=%h din0=%h, want 0", sram_addr0, sram_addr1, sram_din0);
    end
    checks++;
    if ({i_ack, i_err, d_ack, d_err} !== 4'b0000 || i_rdata !== 32'd0 || d_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_handshake: got acks/errs=%b%b%b%b i_rdata=%h d_rdata=%h, want all 0", i_ack, i_err, d_ack, d_err, i_rdata, d_rdata);
    end
    @(negedge clk);
    nRst = 1'b1;
    step();
  endtask

  task automatic test_write();
    d_req = 1'b1; d_we = 1'b1; d_sel = 4'hF; d_addr = 32'h0000_0010; d_wdata = 32'hDEAD_BEEF;
    step();
    checks++;
    if (sram_csb0 !== 1'b0 || sram_addr0 !== 11'd4 || sram_din0 !== 32'hDEAD_BEEF || sram_wmask0 !== 4'hF) begin
      errors++;
      $display("FAIL write_cmd: got csb0=%b addr0=%h din0=%h wmask0=%h, want 0 004 deadbeef f", sram_csb0, sram_addr0, sram_din0, sram_wmask0);
    end
    step();
    checks++;
    if (d_ack !== 1'b1 || d_err !== 1'b0 || sram_csb0 !== 1'b1 || sram_wmask0 !== 4'h0) begin
      errors++;
      $display("FAIL write_ack: got d_ack=%b d_err=%b csb0=%b wmask0=%h, want 1 0 1 0", d_ack, d_err, sram_csb0, sram_wmask0);
    end
    d_req = 1'b0;
    step();
    checks++;
    if (d_ack !== 1'b0) begin
      errors++;
      $display("FAIL write_ack_width: got d_ack=%b, want 0", d_ack);
    end
  endtask

  task automatic test_read();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0010;
    step();
    checks++;
    if (sram_csb1 !== 1'b0 || sram_addr1 !== 11'd4 || sram_csb0 !== 1'b1) begin
      errors++;
      $display("FAIL read_cmd: got csb1=%b addr1=%h csb0=%b, want 0 004 1", sram_csb1, sram_addr1, sram_csb0);
    end
    step();
    checks++;
    if (sram_csb1 !== 1'b1 || d_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_rd0: got csb1=%b d_ack=%b, want 1 0", sram_csb1, d_ack);
    end
    step();
    checks++;
    if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_ack: got d_ack=%b d_err=%b d_rdata=%h, want 1 0 deadbeef", d_ack, d_err, d_rdata);
    end
    d_req = 1'b0;
    step();
    checks++;
    if (d_ack !== 1'b0 || d_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_hold: got d_ack=%b d_rdata=%h, want 0 deadbeef", d_ack, d_rdata);
    end
  endtask

  task automatic test_byte_mask();
    int lat;
    d_txn(1'b1, 4'b0010, 32'h0000_0010, 32'h0000_5500, lat);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL mask_write_latency: got %0d, want 2", lat);
    end
    d_txn(1'b0, 4'h0, 32'h0000_0010, 32'h0, lat);
    checks++;
    if (lat != 3 || d_rdata !== 32'hDEAD_55EF) begin
      errors++;
      $display("FAIL mask_readback: got lat=%0d rdata=%h, want 3 dead55ef", lat, d_rdata);
    end
    d_txn(1'b1, 4'b0000, 32'h0000_0010, 32'hFFFF_FFFF, lat);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL sel0_write_ack: got latency %0d, want 2", lat);
    end
    d_txn(1'b0, 4'h0, 32'h0000_0013, 32'h0, lat);
    checks++;
    if (lat != 3 || d_rdata !== 32'hDEAD_55EF) begin
      errors++;
      $display("FAIL sel0_unchanged: got lat=%0d rdata=%h, want 3 dead55ef", lat, d_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic got_d [4];
    int   n = 0;
    logic prev_i = 1'b0;
    logic prev_d = 1'b0;
    nRst = 1'b0;
    i_req = 1'b1; i_addr = 32'h0000_0040;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0020;
    @(negedge clk);
    nRst = 1'b1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step();
      checks++;
      if ((i_ack && d_ack) || (!sram_csb0 && !sram_csb1) || (i_ack && prev_i) || (d_ack && prev_d)) begin
        errors++;
        $display("FAIL rr_overlap: got i_ack=%b d_ack=%b csb0=%b csb1=%b prev=%b%b, want single 1-cycle ack", i_ack, d_ack, sram_csb0, sram_csb1, prev_i, prev_d);
      end
      if (d_ack) begin
        got_d[n] = 1'b1;
        n++;
        checks++;
        if (d_rdata !== pat(8)) begin
          errors++;
          $display("FAIL rr_d_rdata: got %h, want %h", d_rdata, pat(8));
        end
      end else if (i_ack) begin
        got_d[n] = 1'b0;
        n++;
        checks++;
        if (i_rdata !== pat(16)) begin
          errors++;
          $display("FAIL rr_i_rdata: got %h, want %h", i_rdata, pat(16));
        end
      end
      prev_i = i_ack;
      prev_d = d_ack;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rr_timeout: got %0d acks, want 4", n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_d[k] !== ((k % 2) == 0)) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %s, want %s", k, got_d[k] ? "D" : "I", ((k % 2) == 0) ? "D" : "I");
        end
      end
    end
    step();
  endtask

  task automatic test_out_of_range();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
    step();
    checks++;
    if (d_ack !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'd0 || sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) begin
      errors++;
      $display("FAIL oor_d: got ack=%b err=%b rdata=%h csb0=%b csb1=%b, want 1 1 0 1 1", d_ack, d_err, d_rdata, sram_csb0, sram_csb1);
    end
    d_req = 1'b0;
    step();
    checks++;
    if (d_ack !== 1'b0 || d_err !== 1'b0 || sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) begin
      errors++;
      $display("FAIL oor_d_done: got ack=%b err=%b csb0=%b csb1=%b, want 0 0 1 1", d_ack, d_err, sram_csb0, sram_csb1);
    end
    i_req = 1'b1; i_addr = 32'hFFFF_0004;
    d_we = 1'b1;
    step();
    checks++;
    if (i_ack !== 1'b1 || i_err !== 1'b1 || i_rdata !== 32'd0 || sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) begin
      errors++;
      $display("FAIL oor_i: got ack=%b err=%b rdata=%h csb0=%b csb1=%b, want 1 1 0 1 1", i_ack, i_err, i_rdata, sram_csb0, sram_csb1);
    end
    i_req = 1'b0;
    d_we = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_write();
    int lat;
    logic saw_ack = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_sel = 4'hF; d_addr = 32'h0000_0030; d_wdata = 32'h1234_5678;
    step();
    checks++;
    if (sram_csb0 !== 1'b0) begin
      errors++;
      $display("FAIL abort_cmd: got csb0=%b, want 0", sram_csb0);
    end
    #2;
    nRst = 1'b0;
    d_req = 1'b0;
    #1;
    checks++;
    if (sram_csb0 !== 1'b1) begin
      errors++;
      $display("FAIL abort_async_csb0: got csb0=%b, want 1", sram_csb0);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      if (d_ack === 1'b1) saw_ack = 1'b1;
    end
    @(negedge clk);
    nRst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      if (d_ack === 1'b1) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack) begin
      errors++;
      $display("FAIL abort_no_ack: got an ack for the aborted write, want none");
    end
    d_txn(1'b0, 4'h0, 32'h0000_0030, 32'h0, lat);
    checks++;
    if (lat != 3 || d_rdata !== pat(12)) begin
      errors++;
      $display("FAIL abort_old_data: got lat=%0d rdata=%h, want 3 %h", lat, d_rdata, pat(12));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = pat(i);
    sram_dout1 = '0;
    test_reset();
    test_write();
    test_read();
    test_byte_mask();
    test_round_robin();
    test_out_of_range();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
Front-end controller that sits directly upstream of the 2048x32 dual-port SRAM macro (port 0 write with byte mask, port 1 read, inputs captured on posedge, array access on negedge). It arbitrates round-robin between a read-only instruction-fetch requester (I) and a read/write data requester (D). It translates byte addresses into SRAM word addresses, sequences the SRAM's one-cycle capture latency, and returns a registered ack/rdata/err handshake. Only one transaction is in flight at a time.

Parameters:
ADDR_WIDTH, 11, SRAM word-address width (depth = 2^ADDR_WIDTH words)
DATA_WIDTH, 32, SRAM data width
NUM_WMASKS, 4, byte-lane count (DATA_WIDTH/8)
BASE_ADDR, 32'h0000_0000, byte base of the SRAM window; aligned to 4*2^ADDR_WIDTH

Ports:
clk  in  1  system clock (shared with SRAM clk0/clk1)
nRst  in  1  asynchronous active-low reset
i_req  in  1  instruction read request, held until i_ack
i_addr  in  32  instruction byte address
i_ack  out  1  one-cycle completion pulse
i_err  out  1  valid with i_ack; address outside window
i_rdata  out  DATA_WIDTH  read data, valid with i_ack
d_req  in  1  data request, held until d_ack
d_we  in  1  1=write, 0=read
d_sel  in  NUM_WMASKS  byte enables for writes
d_addr  in  32  data byte address
d_wdata  in  DATA_WIDTH  write data
d_ack  out  1  one-cycle completion pulse
d_err  out  1  valid with d_ack; address outside window
d_rdata  out  DATA_WIDTH  read data, valid with d_ack
sram_csb0  out  1  SRAM write chip select, active low
sram_wmask0  out  NUM_WMASKS  SRAM write mask
sram_addr0  out  ADDR_WIDTH  SRAM write word address
sram_din0  out  DATA_WIDTH  SRAM write data
sram_csb1  out  1  SRAM read chip select, active low
sram_addr1  out  ADDR_WIDTH  SRAM read word address
sram_dout1  in  DATA_WIDTH  SRAM read data

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low on nRst. All outputs are registered.
- Reset values: csb0=1, csb1=1, wmask0=0, addr0/addr1/din0=0, all ack/err=0, all rdata=0, state=IDLE, last_grant=I.
- States: IDLE, WR, RD0, RD1, DONE.
- IDLE, arbitration: evaluated each posedge in IDLE.
  - Only one requester high: grant it.
  - Both high: grant the one not equal to last_grant. After reset, the first tie goes to D.
  - Update last_grant on every grant.
- Address decode:
  - word = addr[ADDR_WIDTH+1:2].
  - In range iff addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2].
  - addr[1:0] is ignored; there is no misalignment error.
- Grant, out of range: go to DONE with err=1 and rdata=0. No SRAM chip select is asserted.
- Grant, D write: register csb0=0, wmask0=d_sel, addr0=word, din0=d_wdata, then go to WR.
- Grant, read (I, or D with d_we=0): register csb1=0, addr1=word, then go to RD0.
- WR: csb0 returns to 1 and wmask0 to 0; go to DONE. The SRAM captured the command at this edge and commits it on the following negedge.
- RD0: csb1 returns to 1; go to RD1. The SRAM captured the command at this edge and drives dout1 on the following negedge.
- RD1: capture sram_dout1 into the granted port's rdata; go to DONE.
- DONE:
  - The granted port's ack is high for exactly this one cycle; err is as decided at grant.
  - req is ignored.
  - Return to IDLE.
  - rdata holds its value until the next read completion on that port.
- Latency (request sampled at edge k; ack high in the cycle after the listed edge):
  - Write: edge k+1.
  - Read: edge k+2.
  - Out of range: edge k.
- Requester rule: drop req, or present a new request, in the cycle ack is seen. A request already held is re-arbitrated at the first IDLE edge.
- d_sel=0 write: full WR sequence with wmask0=0. Memory is unchanged; ack is still returned.
- Port I never writes. d_we has no effect on I.
- Ordering: a read issued after a write's ack observes the written data, because the write commits before the next read capture.
- Reset mid-transaction: nRst forces csb0/csb1 high immediately.
  - A write whose capture edge has not occurred is dropped.
  - No ack is generated for the aborted transaction; the requester reissues it.

Decomposition:
- Package sram_arb_pkg: state enum (IDLE, WR, RD0, RD1, DONE), port-id enum (PORT_I, PORT_D), and the window-match helper constant (ADDR_WIDTH+2).
- One sub-module: sram_rr_arbiter, a 2-way round-robin grant with last_grant register, combinational grant output, and update enable from the FSM.

Test Plan:
- Reset, then D write 0x0000_0010 / 0xDEADBEEF / sel=4'hF:
  - Edge after accept: csb0=0, addr0=4, din0=DEADBEEF.
  - d_ack one cycle later, d_err=0.
- D read 0x0000_0010 after that write -> csb1=0 with addr1=4 for one cycle; d_ack 2 cycles after accept with d_rdata=0xDEADBEEF.
- D write sel=4'b0010 data 0x0000_5500 to the same word, then read -> 0xDEAD55EF. A write with sel=0, then read -> value unchanged, and that write is still acked.
- i_req and d_req both asserted continuously from reset to distinct words -> grants alternate D, I, D, I. Each ack is one cycle wide. No overlapping SRAM selects.
- Access to 0x0000_2000 (just past the 8 KB window) with BASE_ADDR=0 -> ack the edge after accept, err=1, rdata=0, csb0 and csb1 never low.
- Pull nRst low in the WR-pending cycle after accepting a write -> csb0 goes high asynchronously, no ack. After release, a read of that word returns the old contents.
